// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with a circular return-address stack,
// a configurable reset vector and target-alignment fault detection.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              INC          = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2:0]                     mode,
    input  logic [XLEN-1:0]                update,
    input  logic                           update_en,
    output logic [XLEN-1:0]                current,
    output logic [XLEN-1:0]                next,
    output logic [XLEN-1:0]                ras_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           fault,
    output logic                           underflow
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
    localparam logic [XLEN-1:0] ZERO_X     = {XLEN{1'b0}};
    localparam logic [CW-1:0]   DEPTH_C    = CW'(RAS_DEPTH);
    localparam logic [CW-1:0]   ZERO_C     = {CW{1'b0}};
    localparam logic [PW-1:0]   LAST_PTR   = PW'(RAS_DEPTH - 1);
    localparam logic [PW-1:0]   ZERO_P     = {PW{1'b0}};

    localparam logic [2:0] M_INC      = 3'd0;
    localparam logic [2:0] M_ADD      = 3'd1;
    localparam logic [2:0] M_SET      = 3'd2;
    localparam logic [2:0] M_CALL_ADD = 3'd3;
    localparam logic [2:0] M_CALL_SET = 3'd4;
    localparam logic [2:0] M_RET      = 3'd5;
    localparam logic [2:0] M_FLUSH    = 3'd6;
    localparam logic [2:0] M_HOLD     = 3'd7;

    logic [XLEN-1:0] current_r;
    logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0]   top_ptr_r;
    logic [CW-1:0]   count_r;
    logic            fault_r;
    logic            underflow_r;

    logic [XLEN-1:0] target_s;
    logic            active_s;
    logic            push_s;
    logic            pop_s;
    logic            flush_s;
    logic            under_s;
    logic            reject_s;

    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return (addr & ALIGN_MASK) != ZERO_X;
    endfunction

    // The stack is a ring: advancing past the last slot overwrites the oldest entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? ZERO_P : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == ZERO_P) ? LAST_PTR : p - PW'(1);
    endfunction

    assign current   = current_r;
    assign next      = current_r + INC_V;
    assign ras_count = count_r;
    assign ras_empty = (count_r == ZERO_C);
    assign ras_full  = (count_r == DEPTH_C);
    assign ras_top   = ras_empty ? ZERO_X : ras_mem_r[top_ptr_r];
    assign fault     = fault_r;
    assign underflow = underflow_r;

    // Decode the mode into a target address and the stack operation it implies.
    always_comb begin
        target_s = current_r;
        active_s = update_en;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        flush_s  = 1'b0;
        under_s  = 1'b0;
        case (mode)
            M_INC:      target_s = next;
            M_ADD:      target_s = current_r + update;
            M_SET:      target_s = update;
            M_CALL_ADD: begin
                target_s = current_r + update;
                push_s   = 1'b1;
            end
            M_CALL_SET: begin
                target_s = update;
                push_s   = 1'b1;
            end
            M_RET: begin
                if (ras_empty) begin
                    target_s = update;
                    under_s  = 1'b1;
                end else begin
                    target_s = ras_top;
                    pop_s    = 1'b1;
                end
            end
            M_FLUSH: begin
                target_s = update;
                flush_s  = 1'b1;
            end
            M_HOLD:  active_s = 1'b0;
            default: active_s = 1'b0;
        endcase
        reject_s = misaligned(target_s);
    end

    // PC, return stack and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            current_r   <= RESET_VECTOR;
            top_ptr_r   <= ZERO_P;
            count_r     <= ZERO_C;
            fault_r     <= 1'b0;
            underflow_r <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= ZERO_X;
            end
        end else if (active_s) begin
            fault_r     <= reject_s;
            underflow_r <= under_s & ~reject_s;
            if (!reject_s) begin
                current_r <= target_s;
                if (push_s) begin
                    top_ptr_r                     <= ptr_inc(top_ptr_r);
                    ras_mem_r[ptr_inc(top_ptr_r)] <= next;
                    if (!ras_full) begin
                        count_r <= count_r + CW'(1);
                    end
                end else if (pop_s) begin
                    top_ptr_r <= ptr_dec(top_ptr_r);
                    count_r   <= count_r - CW'(1);
                end else if (flush_s) begin
                    count_r <= ZERO_C;
                end
            end
        end else begin
            fault_r     <= 1'b0;
            underflow_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_pc_sequencer;

    typedef struct {
        string       name;
        logic [31:0] cur;
        logic [2:0]  cnt;
        logic [31:0] top;
        logic        f;
        logic        u;
        logic        c2;
        logic [31:0] cur2;
        logic        f2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  mode = 3'd7;
    logic [31:0] update = 32'h0;
    logic        update_en = 1'b0;

    logic [31:0] current, next, ras_top;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, fault, underflow;

    logic [31:0] current2, next2, ras_top2;
    logic [2:0]  ras_count2;
    logic        ras_empty2, ras_full2, fault2, underflow2;

    exp_t sb[$];
    exp_t e;
    int   applied = 0;
    int   miscompares = 0;

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h100), .INC(4), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .update(update), .update_en(update_en),
        .current(current), .next(next), .ras_top(ras_top), .ras_count(ras_count),
        .ras_empty(ras_empty), .ras_full(ras_full), .fault(fault), .underflow(underflow)
    );

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h100), .INC(2), .RAS_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .mode(mode), .update(update), .update_en(update_en),
        .current(current2), .next(next2), .ras_top(ras_top2), .ras_count(ras_count2),
        .ras_empty(ras_empty2), .ras_full(ras_full2), .fault(fault2), .underflow(underflow2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string vname, input string field, input logic [31:0] act,
                       input logic [31:0] expv);
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", vname, field, act, expv);
        end
    endtask

    // Monitor: one expectation per clock edge, compared on the following negedge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            applied++;
            chk(e.name, "current",   current,           e.cur);
            chk(e.name, "next",      next,              e.cur + 32'd4);
            chk(e.name, "ras_count", {29'd0, ras_count}, {29'd0, e.cnt});
            chk(e.name, "ras_top",   ras_top,           e.top);
            chk(e.name, "ras_empty", {31'd0, ras_empty}, {31'd0, (e.cnt == 3'd0)});
            chk(e.name, "ras_full",  {31'd0, ras_full},  {31'd0, (e.cnt == 3'd4)});
            chk(e.name, "fault",     {31'd0, fault},     {31'd0, e.f});
            chk(e.name, "underflow", {31'd0, underflow}, {31'd0, e.u});
            if (e.c2) begin
                chk(e.name, "inc2_current", current2,        e.cur2);
                chk(e.name, "inc2_fault",   {31'd0, fault2}, {31'd0, e.f2});
            end
        end
    end

    task automatic vec(input string name, input logic r, input logic en, input logic [2:0] m,
                       input logic [31:0] upd, input logic [31:0] cur, input logic [2:0] cnt,
                       input logic [31:0] top, input logic f, input logic u,
                       input logic c2 = 1'b0, input logic [31:0] cur2 = 32'h0,
                       input logic f2 = 1'b0);
        exp_t x;
        rst = r; update_en = en; mode = m; update = upd;
        x.name = name; x.cur = cur; x.cnt = cnt; x.top = top; x.f = f; x.u = u;
        x.c2 = c2; x.cur2 = cur2; x.f2 = f2;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    localparam logic [2:0] INC_M = 3'd0, ADD = 3'd1, SET = 3'd2, CADD = 3'd3,
                           CSET = 3'd4, RET = 3'd5, FLSH = 3'd6, HOLD = 3'd7;

    initial begin
        //     name          rst   en    mode  update         current        cnt   top          f     u
        vec("reset",         1'b1, 1'b0, HOLD, 32'h0,         32'h100,       3'd0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        vec("idle1",         1'b0, 1'b0, INC_M,32'h0,         32'h100,       3'd0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        vec("idle2",         1'b0, 1'b0, SET,  32'h40,        32'h100,       3'd0, 32'h0,       1'b0, 1'b0);
        vec("idle3",         1'b0, 1'b0, CSET, 32'h40,        32'h100,       3'd0, 32'h0,       1'b0, 1'b0);
        vec("inc1",          1'b0, 1'b1, INC_M,32'h0,         32'h104,       3'd0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h102, 1'b0);
        vec("inc2",          1'b0, 1'b1, INC_M,32'h0,         32'h108,       3'd0, 32'h0,       1'b0, 1'b0);
        vec("add_c",         1'b0, 1'b1, ADD,  32'hC,         32'h114,       3'd0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h110, 1'b0);
        vec("set_124",       1'b0, 1'b1, SET,  32'h124,       32'h124,       3'd0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h124, 1'b0);
        vec("set_122_mis",   1'b0, 1'b1, SET,  32'h122,       32'h124,       3'd0, 32'h0,       1'b1, 1'b0, 1'b1, 32'h122, 1'b0);
        vec("set_122_again", 1'b0, 1'b1, SET,  32'h122,       32'h124,       3'd0, 32'h0,       1'b1, 1'b0);
        vec("hold_clr",      1'b0, 1'b1, HOLD, 32'h0,         32'h124,       3'd0, 32'h0,       1'b0, 1'b0);
        vec("set_8",         1'b0, 1'b1, SET,  32'h8,         32'h8,         3'd0, 32'h0,       1'b0, 1'b0);
        vec("add_wrap",      1'b0, 1'b1, ADD,  32'hFFFFFFF0,  32'hFFFFFFF8,  3'd0, 32'h0,       1'b0, 1'b0);
        vec("inc_top",       1'b0, 1'b1, INC_M,32'h0,         32'hFFFFFFFC,  3'd0, 32'h0,       1'b0, 1'b0);
        vec("inc_wrap",      1'b0, 1'b1, INC_M,32'h0,         32'h0,         3'd0, 32'h0,       1'b0, 1'b0);
        vec("set_200",       1'b0, 1'b1, SET,  32'h200,       32'h200,       3'd0, 32'h0,       1'b0, 1'b0);
        vec("call_set_400",  1'b0, 1'b1, CSET, 32'h400,       32'h400,       3'd1, 32'h204,     1'b0, 1'b0);
        vec("call_add_10",   1'b0, 1'b1, CADD, 32'h10,        32'h410,       3'd2, 32'h404,     1'b0, 1'b0);
        vec("en0_call",      1'b0, 1'b0, CSET, 32'h700,       32'h410,       3'd2, 32'h404,     1'b0, 1'b0);
        vec("ret1",          1'b0, 1'b1, RET,  32'h0,         32'h404,       3'd1, 32'h204,     1'b0, 1'b0);
        vec("ret2",          1'b0, 1'b1, RET,  32'h0,         32'h204,       3'd0, 32'h0,       1'b0, 1'b0);
        vec("set_0",         1'b0, 1'b1, SET,  32'h0,         32'h0,         3'd0, 32'h0,       1'b0, 1'b0);
        vec("push1",         1'b0, 1'b1, CSET, 32'h10,        32'h10,        3'd1, 32'h4,       1'b0, 1'b0);
        vec("push2",         1'b0, 1'b1, CSET, 32'h20,        32'h20,        3'd2, 32'h14,      1'b0, 1'b0);
        vec("push3",         1'b0, 1'b1, CSET, 32'h30,        32'h30,        3'd3, 32'h24,      1'b0, 1'b0);
        vec("push4_full",    1'b0, 1'b1, CSET, 32'h40,        32'h40,        3'd4, 32'h34,      1'b0, 1'b0);
        vec("push5_over",    1'b0, 1'b1, CSET, 32'h50,        32'h50,        3'd4, 32'h44,      1'b0, 1'b0);
        vec("pop1",          1'b0, 1'b1, RET,  32'h0,         32'h44,        3'd3, 32'h34,      1'b0, 1'b0);
        vec("pop2",          1'b0, 1'b1, RET,  32'h0,         32'h34,        3'd2, 32'h24,      1'b0, 1'b0);
        vec("pop3",          1'b0, 1'b1, RET,  32'h0,         32'h24,        3'd1, 32'h14,      1'b0, 1'b0);
        vec("pop4",          1'b0, 1'b1, RET,  32'h0,         32'h14,        3'd0, 32'h0,       1'b0, 1'b0);
        vec("pop5_under",    1'b0, 1'b1, RET,  32'h800,       32'h800,       3'd0, 32'h0,       1'b0, 1'b1);
        vec("ret_under_mis", 1'b0, 1'b1, RET,  32'h802,       32'h800,       3'd0, 32'h0,       1'b1, 1'b0);
        vec("call_mis",      1'b0, 1'b1, CSET, 32'h303,       32'h800,       3'd0, 32'h0,       1'b1, 1'b0);
        vec("call_900",      1'b0, 1'b1, CSET, 32'h900,       32'h900,       3'd1, 32'h804,     1'b0, 1'b0);
        vec("call_add_100",  1'b0, 1'b1, CADD, 32'h100,       32'hA00,       3'd2, 32'h904,     1'b0, 1'b0);
        vec("flush_mis",     1'b0, 1'b1, FLSH, 32'h81,        32'hA00,       3'd2, 32'h904,     1'b1, 1'b0);
        vec("rst_mid_call",  1'b1, 1'b1, CSET, 32'h400,       32'h100,       3'd0, 32'h0,       1'b0, 1'b0);
        vec("call_500",      1'b0, 1'b1, CSET, 32'h500,       32'h500,       3'd1, 32'h104,     1'b0, 1'b0);
        vec("flush_80",      1'b0, 1'b1, FLSH, 32'h80,        32'h80,        3'd0, 32'h0,       1'b0, 1'b0);
        vec("ret_after_fl",  1'b0, 1'b1, RET,  32'h40,        32'h40,        3'd0, 32'h0,       1'b0, 1'b1);
        vec("hold_end",      1'b0, 1'b1, HOLD, 32'h0,         32'h40,        3'd0, 32'h0,       1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program counter for the fetch stage, and successor to the fixed 32-bit INC/ADD/SET counter. It holds the architectural PC and presents `current` and `next` combinationally to fetch. It adds a configurable return-address stack (RAS) for call/return modes, a reset vector and target-alignment fault detection. It sits between decode/branch resolution (which drive `mode`/`update`) and the instruction fetch unit.

## Interface
- `XLEN`, 32: address width in bits.
- `RESET_VECTOR`, 0: value loaded into PC on reset; must be aligned to `INC`.
- `INC`, 4: byte increment per instruction; power of two, 2 or 4; defines alignment.
- `RAS_DEPTH`, 4: return-address stack entries, ≥1.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `mode`  in  3: 0 INC, 1 ADD, 2 SET, 3 CALL_ADD, 4 CALL_SET, 5 RET, 6 FLUSH, 7 HOLD.
- `update`  in  XLEN: offset (ADD/CALL_ADD) or absolute target (SET/CALL_SET/RET fallback/FLUSH).
- `update_en`  in  1: when 0, no state changes.
- `current`  out  XLEN: registered PC.
- `next`  out  XLEN: combinational `current + INC`, modulo 2^XLEN.
- `ras_top`  out  XLEN: top RAS entry; 0 when empty.
- `ras_count`  out  $clog2(RAS_DEPTH+1): valid entries.
- `ras_empty`, `ras_full`  out  1 each: combinational from `ras_count`.
- `fault`  out  1: registered one-cycle pulse; misaligned target rejected.
- `underflow`  out  1: registered one-cycle pulse; RET executed with empty RAS.

## Operation
- Reset: `current`=RESET_VECTOR, `ras_count`=0, `fault`=0, `underflow`=0, all RAS entries cleared to 0. Reset overrides `update_en`.
- `update_en`=0 or mode HOLD: PC and RAS hold; `fault`/`underflow` return to 0.
- Target per mode (all arithmetic modulo 2^XLEN, wrap silently):
  - INC: `current+INC`.
  - ADD: `current+update`.
  - SET: `update`.
  - CALL_ADD: `current+update`; push `next`.
  - CALL_SET: `update`; push `next`.
  - RET: pop `ras_top` if not empty. If empty: target=`update`, `underflow` pulses, count stays 0.
  - FLUSH: target `update`; `ras_count`→0.
- Alignment: a target with nonzero low log2(INC) bits is rejected. On rejection: PC, RAS and count unchanged; `fault`=1 next cycle; `underflow` not raised. RET pops cannot fault because pushed values are aligned.
- Push when full: the oldest entry is discarded (circular), new entry becomes top, count stays RAS_DEPTH, no flag.
- Pop decrements count; the exposed entry becomes `ras_top`.
- FLUSH with a misaligned `update` faults and does not clear the RAS.

## Timing
- All updates take effect on the rising edge where `update_en`=1. `current` reflects the new value one cycle after the inputs are sampled; `next`, `ras_top`, `ras_empty` and `ras_full` follow combinationally in the same cycle.
- `fault`/`underflow` are high for exactly the cycle after the offending edge, with no stickiness. Back-to-back faults keep them high.
- The push value is `next` sampled at the edge, i.e. the pre-update `current+INC`.
- Inputs may change every cycle; there is no handshake and no stall beyond `update_en`.
- Reset asserted mid-sequence takes effect at the next edge regardless of mode.

## Test plan
- Reset with RESET_VECTOR=0x100, `update_en`=0 for 4 cycles -> `current`=0x100, `next`=0x104, `ras_empty`=1, flags 0 throughout.
- INC ×2, then ADD `update`=0xC, then SET `update`=0x124 -> `current` 0x104, 0x108, 0x114, 0x124. ADD with `update`=0xFFFFFFF0 from 0x8 -> 0xFFFFFFF8 (wrap).
- From 0x200: CALL_SET 0x400, then CALL_ADD 0x10, then RET, then RET -> `current` 0x400, 0x410, 0x404, 0x204. `ras_count` goes 1, 2, 1, 0.
- RAS_DEPTH=4: five CALL_SET pushes from PCs 0x0, 0x10, 0x20, 0x30, 0x40, then five RETs -> returns 0x44, 0x34, 0x24, 0x14. The fifth RET uses `update`=0x800 and `underflow` pulses once.
- SET `update`=0x122 (INC=4) -> `current` unchanged, `fault`=1 for one cycle, RAS unchanged. Repeat with INC=2 -> accepted.
- With 2 entries pushed, assert `rst` concurrently with CALL_SET -> `current`=RESET_VECTOR, `ras_count`=0, no flags. Separately, FLUSH 0x80 -> `current`=0x80, `ras_empty`=1.
